// File: rtl/song_sequencer.sv
// Score player: walks a writable score RAM and drives the four-voice mixer control word.
// Each step holds its notes for a whole number of beats and ends with an all-hushed gap.
module song_sequencer #(
   parameter int TICKS_PER_BEAT = 25000000,
   parameter int GAP_TICKS      = 2500000,
   parameter int DEPTH          = 32,
   parameter int ADDR_W         = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [31:0]       control,
   output logic              playing,
   output logic [ADDR_W-1:0] step_idx,
   output logic              done
);

   localparam int CNT_W = $clog2(15 * TICKS_PER_BEAT + 1);
   localparam logic [CNT_W-1:0]  TPB_C     = CNT_W'(TICKS_PER_BEAT);
   localparam logic [CNT_W-1:0]  NOTE_TRIM = CNT_W'(GAP_TICKS + 1);
   localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
   localparam logic [31:0]       HUSH_ALL  = 32'h000F_0000;
   localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, FETCH, NOTE, GAP} state_t;

   state_t           state;
   logic [23:0]      score [DEPTH];
   logic [23:0]      word;
   logic [3:0]       dur;
   logic [CNT_W-1:0] note_load;
   logic [CNT_W-1:0] note_cnt;
   logic [CNT_W-1:0] gap_cnt;

   // Score RAM is not reset; contents survive a reset so a restart replays the song.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         score[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      word      = score[step_idx];
      dur       = word[23:20];
      note_load = CNT_W'(dur) * TPB_C - NOTE_TRIM;
   end

   // start and stop are one-cycle requests sampled on the clock edge; stop always wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         control  <= HUSH_ALL;
         playing  <= 1'b0;
         step_idx <= '0;
         done     <= 1'b0;
         note_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               control <= HUSH_ALL;
               if (start && !stop) begin
                  state    <= FETCH;
                  step_idx <= '0;
                  playing  <= 1'b1;
               end
            end

            FETCH: begin
               if (stop) begin
                  state    <= IDLE;
                  control  <= HUSH_ALL;
                  playing  <= 1'b0;
                  step_idx <= '0;
               end else if (dur != 4'd0) begin
                  state    <= NOTE;
                  control  <= {12'h000, word[19:0]};
                  note_cnt <= note_load;
               end else if (step_idx == '0 || !loop_en) begin
                  // An end marker at step 0 never loops, so an empty score cannot spin.
                  state    <= IDLE;
                  control  <= HUSH_ALL;
                  playing  <= 1'b0;
                  step_idx <= '0;
                  done     <= 1'b1;
               end else begin
                  step_idx <= '0;
               end
            end

            NOTE: begin
               if (stop) begin
                  state    <= IDLE;
                  control  <= HUSH_ALL;
                  playing  <= 1'b0;
                  step_idx <= '0;
               end else if (note_cnt == '0) begin
                  state           <= GAP;
                  control[19:16]  <= 4'hF;
                  gap_cnt         <= GAP_LOAD;
               end else begin
                  note_cnt <= note_cnt - 1'b1;
               end
            end

            GAP: begin
               if (stop) begin
                  state    <= IDLE;
                  control  <= HUSH_ALL;
                  playing  <= 1'b0;
                  step_idx <= '0;
               end else if (gap_cnt == '0) begin
                  control <= HUSH_ALL;
                  if (step_idx != LAST_STEP) begin
                     state    <= FETCH;
                     step_idx <= step_idx + ADDR_W'(1);
                  end else if (loop_en) begin
                     // Running off the last entry behaves like an end marker.
                     state    <= FETCH;
                     step_idx <= '0;
                  end else begin
                     state    <= IDLE;
                     playing  <= 1'b0;
                     step_idx <= '0;
                     done     <= 1'b1;
                  end
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               control  <= HUSH_ALL;
               playing  <= 1'b0;
               step_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small beat (4 ticks) and 8-entry score.
// Expected per-cycle outputs are queued and compared at the falling clock edge.
module tb_song_sequencer;

   localparam int TPB    = 4;
   localparam int GAP    = 1;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam logic [31:0] HUSH = 32'h000F_0000;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic              start;
   logic              stop;
   logic              loop_en;
   logic [31:0]       control;
   logic              playing;
   logic [ADDR_W-1:0] step_idx;
   logic              done;

   int n_checks = 0;
   int n_pass   = 0;

   // Trace entry: [37] step_idx checked, [36:34] step_idx, [33] done, [32] playing, [31:0] control
   logic [39:0] exp_q[$];

   song_sequencer #(
      .TICKS_PER_BEAT(TPB),
      .GAP_TICKS     (GAP),
      .DEPTH         (DEPTH),
      .ADDR_W        (ADDR_W)
   ) dut (
      .clk     (clk),
      .reset   (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .start   (start),
      .stop    (stop),
      .loop_en (loop_en),
      .control (control),
      .playing (playing),
      .step_idx(step_idx),
      .done    (done)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      wr_en = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic write_step(input logic [ADDR_W-1:0] a, input logic [23:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
   endtask

   task automatic push(input logic care, input logic [2:0] s, input logic d, input logic p,
                       input logic [31:0] c, input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back({2'b00, care, s, d, p, c});
      end
   endtask

   task automatic run_trace(input string tag);
      int cyc;
      logic [39:0] e;
      logic [39:0] g;
      cyc = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {2'b00, e[37], (e[37] ? step_idx : 3'b000), done, playing, control};
         check($sformatf("%s c%0d", tag, cyc), g, e);
         step();
         cyc++;
      end
   endtask

   initial begin
      logic [15:0] nt;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset", {5'b0, step_idx, done, playing, control}, {5'b0, 3'd0, 1'b0, 1'b0, HUSH});
      rst = 1'b0;
      step();
      check("post_reset", {5'b0, step_idx, done, playing, control}, {5'b0, 3'd0, 1'b0, 1'b0, HUSH});

      // 1: one two-beat step then end marker
      write_step(3'd0, 24'h204321);
      write_step(3'd1, 24'h000000);
      pulse_start();
      push(1, 0, 0, 1, HUSH,         1);
      push(1, 0, 0, 1, 32'h0000_4321, 7);
      push(1, 0, 0, 1, 32'h000F_4321, 1);
      push(1, 1, 0, 1, HUSH,         1);
      push(0, 0, 1, 0, HUSH,         1);
      push(0, 0, 0, 0, HUSH,         1);
      run_trace("t1");

      // 2: same score looping, two periods
      loop_en = 1'b1;
      pulse_start();
      for (int r = 0; r < 2; r++) begin
         push(1, 0, 0, 1, HUSH,          1);
         push(1, 0, 0, 1, 32'h0000_4321, 7);
         push(1, 0, 0, 1, 32'h000F_4321, 1);
         push(1, 1, 0, 1, HUSH,          1);
      end
      push(1, 0, 0, 1, HUSH, 1);
      run_trace("t2");
      pulse_stop();
      check("t2 stop", {6'b0, done, playing, control}, {6'b0, 1'b0, 1'b0, HUSH});
      loop_en = 1'b0;

      // 3: full score of one-beat steps, wrap ends the song
      for (int i = 0; i < DEPTH; i++) begin
         nt = 16'(16'h1111 * (i + 1));
         write_step(3'(i), {4'd1, 4'h5, nt});
      end
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         nt = 16'(16'h1111 * (i + 1));
         push(1, 3'(i), 0, 1, HUSH,                  1);
         push(1, 3'(i), 0, 1, {12'h000, 4'h5, nt},   3);
         push(1, 3'(i), 0, 1, {12'h000, 4'hF, nt},   1);
      end
      push(1, 0, 1, 0, HUSH, 1);
      push(1, 0, 0, 0, HUSH, 1);
      run_trace("t3");

      // 4: empty score with looping must not lock up
      write_step(3'd0, 24'h000000);
      loop_en = 1'b1;
      pulse_start();
      push(1, 0, 0, 1, HUSH, 1);
      push(1, 0, 1, 0, HUSH, 1);
      push(1, 0, 0, 0, HUSH, 2);
      run_trace("t4");
      loop_en = 1'b0;

      // 5: start+stop together in IDLE, then stop mid-NOTE
      write_step(3'd0, 24'h204321);
      write_step(3'd1, 24'h000000);
      start = 1'b1;
      stop  = 1'b1;
      step();
      check("t5 both", {6'b0, done, playing, control}, {6'b0, 1'b0, 1'b0, HUSH});
      step();
      step();
      check("t5 both idle", {6'b0, done, playing, control}, {6'b0, 1'b0, 1'b0, HUSH});
      pulse_start();
      push(1, 0, 0, 1, HUSH,          1);
      push(1, 0, 0, 1, 32'h0000_4321, 2);
      run_trace("t5 pre");
      pulse_stop();
      check("t5 stop", {6'b0, done, playing, control}, {6'b0, 1'b0, 1'b0, HUSH});
      step();
      check("t5 stop+1", {6'b0, done, playing, control}, {6'b0, 1'b0, 1'b0, HUSH});

      // 6a: asynchronous reset during GAP; score survives
      pulse_start();
      push(1, 0, 0, 1, HUSH,          1);
      push(1, 0, 0, 1, 32'h0000_4321, 7);
      run_trace("t6 pre");
      check("t6 gap", {8'b0, control}, {8'b0, 32'h000F_4321});
      #2;
      rst = 1'b1;
      #1;
      check("t6 async", {5'b0, step_idx, done, playing, control}, {5'b0, 3'd0, 1'b0, 1'b0, HUSH});
      step();
      rst = 1'b0;
      step();
      pulse_start();
      push(1, 0, 0, 1, HUSH,          1);
      push(1, 0, 0, 1, 32'h0000_4321, 1);
      run_trace("t6 replay");
      pulse_stop();

      // 6b: rewrite the sounding step; change appears on its next fetch
      loop_en = 1'b1;
      pulse_start();
      push(1, 0, 0, 1, HUSH,          1);
      push(1, 0, 0, 1, 32'h0000_4321, 2);
      run_trace("t6b pre");
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_data = 24'h208765;
      push(1, 0, 0, 1, 32'h0000_4321, 5);
      push(1, 0, 0, 1, 32'h000F_4321, 1);
      push(1, 1, 0, 1, HUSH,          1);
      push(1, 0, 0, 1, HUSH,          1);
      push(1, 0, 0, 1, 32'h0000_8765, 2);
      run_trace("t6b");
      pulse_stop();
      loop_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Autonomous score player that generates the 32-bit `control` word consumed by the four-voice piano mixer: notes for voices 1-4 in [15:0] and per-voice hush in [19:16].
- Steps through a writable score RAM, holding each step for a programmed number of beats.
- Inserts an all-voices-hushed articulation gap at the end of every step.
- Sits between the host/register interface (score load, start/stop) and the mixer's control input.

Parameters:
- TICKS_PER_BEAT, 25000000, clk cycles per beat; must be >= 2.
- GAP_TICKS, 2500000, cycles at the end of each step with all voices hushed; must satisfy 1 <= GAP_TICKS < TICKS_PER_BEAT.
- DEPTH, 32, score RAM entries; power of two.
- ADDR_W, 5, log2(DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  score RAM write strobe
- wr_addr  in  ADDR_W  score RAM write address
- wr_data  in  24  step word: [15:0] four 4-bit notes (voice1 in [3:0]), [19:16] hush mask, [23:20] duration in beats (0 = end marker)
- start  in  1  single-cycle start request
- stop  in  1  single-cycle stop request
- loop_en  in  1  replay from step 0 when an end is reached
- control  out  32  registered word to the mixer
- playing  out  1  high in FETCH/NOTE/GAP
- step_idx  out  ADDR_W  address of the current step
- done  out  1  one-cycle pulse when the song ends without looping

Behaviour:
- Reset (async) values:
  - state = IDLE
  - control = 32'h000F_0000
  - playing = 0, step_idx = 0, done = 0
  - tick counters = 0
  - RAM contents are not reset.
- control[31:20] is 0 at all times. In IDLE, control = 32'h000F_0000.
- RAM: DEPTH x 24 register array.
  - Write on the clk edge when wr_en = 1; writes are legal in any state.
  - Read is combinational at step_idx.
  - A write to the step currently sounding does not alter output until that step is next fetched.
- States: IDLE, FETCH, NOTE, GAP.
- IDLE:
  - start = 1 and stop = 0 -> FETCH with step_idx = 0.
  - stop has priority when start and stop arrive in the same cycle.
- FETCH (always exactly 1 cycle): latch the RAM word at step_idx.
  - If dur != 0: next state NOTE.
    - control = {12'h0, hush, notes}.
    - Load remaining = dur*TICKS_PER_BEAT - GAP_TICKS - 1.
  - If dur == 0 (end marker), then:
    - step_idx == 0 -> IDLE and done pulse, regardless of loop_en (guards against spinning on an empty score).
    - loop_en = 1 -> stay in FETCH with step_idx = 0; no done pulse.
    - otherwise -> IDLE, done = 1 for one cycle.
- NOTE:
  - Decrement remaining each cycle.
  - At 0 -> GAP: control[19:16] = 4'hF (notes unchanged), load gap counter = GAP_TICKS - 1.
- GAP:
  - Decrement the gap counter.
  - At 0 -> FETCH with step_idx + 1.
  - If step_idx == DEPTH-1, the wrap is treated as an implicit end marker: same loop/done rules as above, with step_idx -> 0.
- Step timing:
  - NOTE lasts dur*TICKS_PER_BEAT - GAP_TICKS cycles; GAP lasts GAP_TICKS cycles.
  - Step period = dur*TICKS_PER_BEAT + 1 cycles (FETCH included).
- Start latency: start sampled at edge E0 -> FETCH after E0 -> control shows step 0 after E1.
- stop:
  - In any non-IDLE state, stop -> IDLE on the next edge; control = 32'h000F_0000.
  - No done pulse on stop.
- start while playing is ignored.
- Arithmetic:
  - Counter width ceil(log2(15*TICKS_PER_BEAT + 1)).
  - dur*TICKS_PER_BEAT is computed as an unsigned product with no truncation.
- Reset asserted mid-song: immediate return to reset values; RAM retained, so start replays from step 0.

Test Plan:
1. Params TICKS_PER_BEAT=4, GAP_TICKS=1, DEPTH=8. Load step0 = {dur 2, hush 0, notes 16'h4321}, step1 = dur 0. Pulse start -> control = 32'h0000_4321 for 7 cycles, then 32'h000F_4321 for 1 cycle, then 32'h000F_0000 with a done pulse; playing high for exactly 10 cycles.
2. Same score with loop_en=1 -> control repeats 32'h0000_4321 every 10 cycles (9-cycle step period plus 1 FETCH on the end marker); done never asserts; step_idx alternates 0,1.
3. Fill all 8 steps with dur 1, hush 4'b0101, loop_en=0 -> each step shows control[19:16]=5 for 3 cycles then F for 1; after step 7, done pulses and step_idx returns to 0.
4. Step0 dur=0, start with loop_en=1 -> single FETCH cycle, then IDLE with a done pulse; no lock-up.
5. start and stop in the same cycle in IDLE -> remains IDLE. stop mid-NOTE -> next cycle control = 32'h000F_0000, playing = 0, no done.
6. Assert reset mid-GAP -> outputs return to reset values asynchronously (before the next edge). Rewrite step0 during NOTE of step0 -> current output unchanged; new notes appear on the next fetch of step0 (loop_en=1).
